// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan controller for an 8-digit common-anode seven-segment display
// Optional leading-zero suppression: define SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] DATA,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic                    LOAD,
    output logic                    LOAD_ACK,
    output logic [3:0]              NIBBLE,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    DP_N,
    output logic                    FRAME_TICK
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_pend;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_en;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_en;
    logic [NUM_DIGITS-1:0]   r_act_dp;

    logic                    w_cnt_wrap;
    logic                    w_boundary;
    logic                    w_drive;
    logic                    w_show;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_sup;
    logic [NUM_DIGITS-1:0]   w_an;

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_boundary = w_cnt_wrap && (r_idx == IDX_LAST);
    assign w_drive    = (r_cnt >= CNT_DRIVE);
    assign w_nib      = r_act_data[{r_idx, 2'b00} +: 4];
    assign w_show     = w_drive && r_act_en[r_idx] && !w_sup[r_idx];

`ifdef SEG_LZ_BLANK_EN
    // Walk down from the most significant digit; disabled digits neither start nor end a zero run.
    logic w_lead;

    always_comb begin
        w_sup  = '0;
        w_lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (r_act_en[i]) begin
                if ((r_act_data[4*i +: 4] == 4'h0) && !r_act_dp[i]) begin
                    w_sup[i] = w_lead;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
    end
`else
    assign w_sup = '0;
`endif

    always_comb begin
        w_an = '1;
        if (w_show) begin
            w_an[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_pend_en   <= '0;
            r_pend_dp   <= '0;
            r_act_data  <= '0;
            r_act_en    <= '0;
            r_act_dp    <= '0;
            AN          <= '1;
            NIBBLE      <= 4'h0;
            DP_N        <= 1'b1;
            FRAME_TICK  <= 1'b0;
            LOAD_ACK    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            if (w_cnt_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            // A LOAD landing on the boundary edge goes straight to the active frame.
            if (w_boundary) begin
                r_pend <= 1'b0;
                if (LOAD) begin
                    r_act_data <= DATA;
                    r_act_en   <= DIGIT_EN;
                    r_act_dp   <= DP;
                end else if (r_pend) begin
                    r_act_data <= r_pend_data;
                    r_act_en   <= r_pend_en;
                    r_act_dp   <= r_pend_dp;
                end
            end else if (LOAD) begin
                r_pend      <= 1'b1;
                r_pend_data <= DATA;
                r_pend_en   <= DIGIT_EN;
                r_pend_dp   <= DP;
            end

            AN         <= w_an;
            NIBBLE     <= w_drive ? w_nib : 4'h0;
            DP_N       <= ~(w_show && r_act_dp[r_idx]);
            FRAME_TICK <= w_boundary;
            LOAD_ACK   <= w_boundary && (r_pend || LOAD);
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the Nexys4 8-digit common-anode seven-segment display. Holds a frame of hex nibbles, sequences one digit at a time through the shared `segment_driver` decoder by presenting its nibble on `NIBBLE` and driving the matching active-low anode. New frames are committed only at frame boundaries, so a display never shows digits from two different frames.

## Interface
- `NUM_DIGITS`, 8: digits scanned; index width is clog2(NUM_DIGITS).
- `REFRESH_DIV`, 12500: clock cycles per digit slot (100 MHz gives 8 kHz per slot and a 1 kHz frame); must be ≥ 2.
- `BLANK_CYCLES`, 250: leading cycles of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

- `CLK` in 1: system clock, rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `DATA` in 4*NUM_DIGITS: nibble i = DATA[4i+3:4i], digit 0 rightmost.
- `DIGIT_EN` in NUM_DIGITS: 1 = digit i shown.
- `DP` in NUM_DIGITS: 1 = decimal point i lit.
- `LOAD` in 1: capture DATA/DIGIT_EN/DP into the pending frame.
- `LOAD_ACK` out 1: one-cycle pulse when the pending frame becomes active.
- `NIBBLE` out 4: to `segment_driver` IN.
- `AN` out NUM_DIGITS: anodes, active low.
- `DP_N` out 1: decimal point, active low.
- `FRAME_TICK` out 1: one-cycle pulse at each frame boundary.

## Operation
- Registers: slot counter `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..NUM_DIGITS-1), pending frame plus `pend` flag, active frame.
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` increments. `idx` wraps NUM_DIGITS-1 -> 0.
- Slot phases: BLANK when cnt < BLANK_CYCLES, DRIVE otherwise. BLANK -> DRIVE at cnt = BLANK_CYCLES. DRIVE -> BLANK (next idx) at wrap.
- In DRIVE, AN[idx] = 0 iff active DIGIT_EN[idx]=1 and the digit is not suppressed. All other AN bits are 1. DP_N = ~(active DP[idx]) while the digit is shown, else 1. NIBBLE = active nibble idx during DRIVE, 0 during BLANK.
- Frame boundary: cnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1.
- LOAD=1 copies inputs into the pending frame and sets `pend`. Repeated LOADs overwrite; the last one wins.
- At a boundary edge with `pend`=1, pending is copied to active, `pend` is cleared, and LOAD_ACK=1 in the next cycle.
- LOAD asserted in the boundary cycle itself: the inputs bypass the pending frame and commit at that edge.
- Disabled digits keep their time slot; the scan rate does not change.

## Timing
- AN, NIBBLE, DP_N, LOAD_ACK and FRAME_TICK are registered. Each reflects the `cnt`/`idx` value of the previous cycle, i.e. one cycle of latency.
- Reset (asynchronous, while RST_N=0) values:
  - cnt=0, idx=0, pend=0.
  - Active and pending frames all zero, so DIGIT_EN=0.
  - AN = all 1, NIBBLE=0, DP_N=1, LOAD_ACK=0, FRAME_TICK=0.
- After RST_N rises, edge k loads outputs from cnt=k-1. AN[idx] first falls at edge BLANK_CYCLES+1 of the slot and rises at the edge after the slot wraps.
- FRAME_TICK and LOAD_ACK go high together, in the cycle after the boundary edge. Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Reset mid-frame discards both frames; the display is dark until a LOAD is committed.
- Worst-case LOAD-to-display latency: one frame + BLANK_CYCLES + 2 cycles.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero suppression is enabled.
  - Scanning down from digit NUM_DIGITS-1, an enabled digit whose active nibble is 0 is suppressed (AN high, DP_N high) until the first nonzero nibble.
  - Digit 0 is never suppressed.
  - A digit with DP=1 ends the suppression run at that digit.
  - Suppression is evaluated combinationally from the active frame only.
- `SEG_LZ_BLANK_EN` undefined: every enabled digit is shown as-is.

## Test plan
Bench parameters: REFRESH_DIV=16, BLANK_CYCLES=2, NUM_DIGITS=8.
1. Reset state: hold RST_N=0 for 5 cycles, then release -> AN=8'hFF, DP_N=1, NIBBLE=0 throughout. After RST_N rises, the first FRAME_TICK occurs 128 cycles later and no AN bit ever goes low.
2. Single load: LOAD with DATA=32'h89ABCDEF, DIGIT_EN=8'hFF, DP=8'h04.
   - LOAD_ACK pulses with the first FRAME_TICK.
   - The next frame shows NIBBLE F,E,D,C,B,A,9,8 with AN=FE,FD,…,7F, each held for 14 cycles and preceded by 2 cycles of AN=FF.
   - DP_N=0 only during digit 2.
3. Double load: LOAD 32'h11111111, then LOAD 32'h22222222 within the same frame -> one LOAD_ACK, and only 2s are displayed.
4. LOAD in the boundary cycle: LOAD asserted in the boundary cycle -> data is visible in the immediately following frame, and LOAD_ACK coincides with FRAME_TICK.
5. Disabled digits: DIGIT_EN=8'h0F -> AN[7:4] stay 1, and slot timing is unchanged (digit 4 slot = 16 dark cycles).
6. Async reset and leading-zero blanking:
   - Assert RST_N low mid-DRIVE -> AN=FF immediately, without waiting for a clock edge.
   - With SEG_LZ_BLANK_EN defined and DATA=32'h00000500, DIGIT_EN=FF, DP=0 -> only digits 0–2 are lit.
